// File: rtl/sti_deserializer.sv
// STI serial receiver: rebuilds 8/16/24/32-bit words from a 1-bit/cycle stream
// into a single-entry valid/ready buffer, with short/long/overflow error pulses.
module sti_deserializer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             si_valid,
    input  logic             si_data,
    input  logic [1:0]       cfg_length,
    input  logic             cfg_msb,
    input  logic             po_ready,
    output logic [31:0]      po_data,
    output logic [1:0]       po_length,
    output logic             po_valid,
    output logic             err_short,
    output logic             err_long,
    output logic             overflow,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {IDLE, RECV, GAP, DRAIN} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_shift;
    logic [1:0]  r_len;
    logic        r_msb;

    logic [1:0]  w_len;
    logic        w_msb;
    logic [4:0]  w_k;
    logic [5:0]  w_nbits;
    logic [4:0]  w_idx;
    logic [31:0] w_word;
    logic        w_last;
    logic        w_consume;
    logic        w_load;

    // The first bit uses the live config; later bits use the copy captured with it.
    always_comb begin
        w_len     = (r_state == IDLE) ? cfg_length : r_len;
        w_msb     = (r_state == IDLE) ? cfg_msb    : r_msb;
        w_k       = (r_state == IDLE) ? 5'd0       : r_cnt;
        w_nbits   = {1'b0, w_len, 3'b000} + 6'd8;
        w_idx     = w_msb ? 5'(w_nbits - 6'd1 - {1'b0, w_k}) : w_k;
        w_word    = ((r_state == IDLE) ? 32'd0 : r_shift) | (32'(si_data) << w_idx);
        w_last    = (r_state == RECV) && si_valid && ({1'b0, r_cnt} == (w_nbits - 6'd1));
        w_consume = po_valid && po_ready;
        w_load    = w_last && (!po_valid || po_ready);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= 5'd0;
            r_shift   <= 32'd0;
            r_len     <= 2'd0;
            r_msb     <= 1'b0;
            po_data   <= 32'd0;
            po_length <= 2'd0;
            po_valid  <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            overflow  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            err_short <= 1'b0;
            err_long  <= 1'b0;
            overflow  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (si_valid) begin
                        r_len   <= cfg_length;
                        r_msb   <= cfg_msb;
                        r_shift <= w_word;
                        r_cnt   <= 5'd1;
                        r_state <= RECV;
                    end
                end
                RECV: begin
                    if (!si_valid) begin
                        err_short <= 1'b1;
                        r_cnt     <= 5'd0;
                        r_shift   <= 32'd0;
                        r_state   <= IDLE;
                    end else if (w_last) begin
                        r_cnt   <= 5'd0;
                        r_shift <= 32'd0;
                        r_state <= GAP;
                    end else begin
                        r_shift <= w_word;
                        r_cnt   <= r_cnt + 5'd1;
                    end
                end
                GAP: begin
                    if (si_valid) begin
                        err_long <= 1'b1;
                        r_state  <= DRAIN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (!si_valid) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            // A load on the consuming edge replaces the old word without a bubble.
            if (w_load) begin
                po_data   <= w_word;
                po_length <= r_len;
                po_valid  <= 1'b1;
                frame_cnt <= frame_cnt + CNT_ONE;
            end else begin
                if (w_consume) po_valid <= 1'b0;
                if (w_last)    overflow <= 1'b1;
            end
        end
    end

endmodule
